// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: default sizes and pointer/count types shared by the FIFO files
package sync_fifo_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF = 16;
  typedef logic [$clog2(DEPTH_DEF)-1:0] ptr_t;
  typedef logic [$clog2(DEPTH_DEF):0] cnt_t;
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x DATA_W storage, one write port, one registered read port
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] ra,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // storage array is deliberately left unreset
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end
  // read data register clears on reset and holds when no read is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[ra];
  end
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty flags; SYNC_FIFO_ERR_EN adds overflow/underflow pulses
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic wr_en, rd_en;
  assign full = count == DEPTH[AW:0];
  assign empty = count == '0;
  assign wr_en = wr & ~full;
  assign rd_en = rd & ~empty;
  // pointers wrap naturally since DEPTH is a power of two; count tracks occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      count <= (wr_en && !rd_en) ? count + 1'b1 : (rd_en && !wr_en) ? count - 1'b1 : count;
    end
  end
`ifdef SYNC_FIFO_ERR_EN
  // one-cycle pulses flagging a refused write or read request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= wr & full;
      underflow <= rd & empty;
    end
  end
`endif
  sync_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .rst(rst),
    .we(wr_en),
    .wa(wptr),
    .wd(din),
    .re(rd_en),
    .ra(rptr),
    .rdata(dout)
  );
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed and random scoreboard checks of sync_fifo
module tb_sync_fifo;
  logic clk = 1'b0;
  logic rst, wr, rd;
  logic [7:0] din, dout;
  logic full, empty;
`ifdef SYNC_FIFO_ERR_EN
  logic overflow, underflow;
  logic exp_ov, exp_un;
`endif
  int total = 0;
  int bad = 0;
  logic [7:0] q[$];
  logic [7:0] exp_d;
  sync_fifo #(.DATA_W(8), .DEPTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .wr(wr),
    .rd(rd),
    .din(din),
    .dout(dout),
    .full(full),
    .empty(empty)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .overflow(overflow),
    .underflow(underflow)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic flags(input string tag);
    chk({tag, "_dout"}, {24'd0, dout}, {24'd0, exp_d});
    chk({tag, "_empty"}, {31'd0, empty}, {31'd0, q.size() == 0});
    chk({tag, "_full"}, {31'd0, full}, {31'd0, q.size() == 16});
  endtask
  task automatic step(input logic w, input logic r, input logic [7:0] d, input string tag);
    bit wa, ra;
    @(negedge clk);
    wr = w;
    rd = r;
    din = d;
    wa = w && q.size() < 16;
    ra = r && q.size() > 0;
`ifdef SYNC_FIFO_ERR_EN
    exp_ov = w && q.size() == 16;
    exp_un = r && q.size() == 0;
`endif
    if (ra) exp_d = q.pop_front();
    if (wa) q.push_back(d);
    @(posedge clk);
    #1;
    flags(tag);
`ifdef SYNC_FIFO_ERR_EN
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ov});
    chk({tag, "_unf"}, {31'd0, underflow}, {31'd0, exp_un});
`endif
    wr = 1'b0;
    rd = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    wr = 1'b0;
    rd = 1'b0;
    din = '0;
    exp_d = '0;
    #15;
    flags("reset");
`ifdef SYNC_FIFO_ERR_EN
    chk("reset_ovf", {31'd0, overflow}, 32'd0);
    chk("reset_unf", {31'd0, underflow}, 32'd0);
`endif
    #5;
    rst = 1'b0;
    step(1'b1, 1'b0, 8'hA5, "first_wr");
    step(1'b0, 1'b1, 8'h00, "first_rd");
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i), "fill");
    step(1'b1, 1'b0, 8'hFF, "wr_full");
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, "drain");
    step(1'b0, 1'b1, 8'h00, "rd_empty");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h20 + i), "load5");
    step(1'b1, 1'b1, 8'h99, "wr_rd_5");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, "unload5");
    step(1'b1, 1'b1, 8'h77, "wr_rd_empty");
    step(1'b0, 1'b1, 8'h00, "rd_77");
    for (int i = 0; i < 30; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom), "rand");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h3C + i), "pre_rst_wr");
    step(1'b0, 1'b1, 8'h00, "pre_rst_rd");
    #2;
    rst = 1'b1;
    q.delete();
    exp_d = '0;
    #1;
    flags("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 8'h5A, "post_rst_wr");
    step(1'b0, 1'b1, 8'h00, "post_rst_rd");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
